cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_controller_pkg.sv | 62 ++++++
 rtl/cpu_controller.sv | 170 +++++++++++++++++
 tb/tb_cpu_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_controller_pkg.sv
// Shared encodings for the CPU controller and datapath: opcodes, datapath
// micro-op enums, controller states and the two TX-buffer decode helpers.
package cpu_controller_pkg;

   localparam logic [5:0] OP_HALT   = 6'h00;
   localparam logic [5:0] OP_PRINTC = 6'h01;
   localparam logic [5:0] OP_PRINTS = 6'h02;
   localparam logic [5:0] OP_PRINTI = 6'h03;
   localparam logic [5:0] OP_PRINTF = 6'h04;
   localparam logic [5:0] OP_PRINTW = 6'h05;
   localparam logic [5:0] OP_LD     = 6'h18;
   localparam logic [5:0] OP_ST     = 6'h19;
   localparam logic [5:0] OP_JMP    = 6'h1B;
   localparam logic [5:0] OP_BEQ    = 6'h1C;
   localparam logic [5:0] OP_BNE    = 6'h1D;
   localparam logic [5:0] OP_LDR    = 6'h1F;

   typedef enum logic [2:0] {
      MAR_NOOP, MAR_PC, MAR_PC_INCR, MAR_RA, MAR_JMP, MAR_INCR
   } mar_op_t;

   typedef enum logic {IR_NOOP, IR_DATA} ir_op_t;
   typedef enum logic {MDR_NOOP, MDR_RC} mdr_op_t;

   typedef enum logic [2:0] {
      PC_NOOP, PC_INCR, PC_JMP, PC_RA, PC_MAR, PC_INCR2
   } pc_op_t;

   typedef enum logic [3:0] {
      TX_NOOP, TX_DATA_1, TX_DATA_2, TX_DATA_3, TX_DATA_4,
      TX_CHARS_1, TX_CHARS_2, TX_CHARS_3, TX_ERR, TX_INT,
      TX_FLOAT, TX_INT_RA, TX_FLOAT_RA
   } tx_op_t;

   typedef enum logic [1:0] {RC_NOOP, RC_PC_INCR, RC_DATA, RC_ARC} rc_op_t;
   typedef enum logic {ARA_NOOP, ARA_RA} ara_op_t;
   typedef enum logic [1:0] {ARB_NOOP, ARB_RB, ARB_LIT} arb_op_t;

   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_FWAIT, S_LOADIR, S_DECODE, S_ALUWB,
      S_LDWAIT, S_LDWB, S_STWAIT, S_STDONE, S_SWAIT, S_STREMIT,
      S_WWAIT, S_WEMIT, S_HALT
   } state_t;

   // PRINTC emits only the leading run of nonzero chars A, B, C.
   function automatic tx_op_t printc_op(input logic [20:0] chars);
      if (chars[20:14] == 7'd0)    return TX_NOOP;
      else if (chars[13:7] == 7'd0) return TX_CHARS_1;
      else if (chars[6:0] == 7'd0)  return TX_CHARS_2;
      else                          return TX_CHARS_3;
   endfunction

   // A string word emits its leading run of nonzero chars, MSB char first.
   function automatic tx_op_t stremit_op(input logic [3:0] nz);
      if (!nz[3])      return TX_NOOP;
      else if (!nz[2]) return TX_DATA_1;
      else if (!nz[1]) return TX_DATA_2;
      else if (!nz[0]) return TX_DATA_3;
      else             return TX_DATA_4;
   endfunction

endpackage

// File: rtl/cpu_controller.sv
// Multi-cycle CPU control FSM: one state register plus one combinational
// block producing next state and all datapath micro-ops.
module cpu_controller
   import cpu_controller_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR,
   input  logic        RaZero,
   input  logic [3:0]  charsZero,
   output mar_op_t     MARop,
   output ir_op_t      IRop,
   output mdr_op_t     MDRop,
   output pc_op_t      PCop,
   output tx_op_t      TXBUFop,
   output rc_op_t      RCop,
   output ara_op_t     ARAop,
   output arb_op_t     ARBop,
   output logic        rdEnnxt,
   output logic        wrEnnxt,
   output state_t      fsm_state
);

   state_t     state;
   state_t     state_next;
   logic [5:0] opcode;
   logic       unused_ir;

   assign opcode    = IR[31:26];
   assign unused_ir = ^IR[25:21];
   assign fsm_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_RESET;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      MARop      = MAR_NOOP;
      IRop       = IR_NOOP;
      MDRop      = MDR_NOOP;
      PCop       = PC_NOOP;
      TXBUFop    = TX_NOOP;
      RCop       = RC_NOOP;
      ARAop      = ARA_NOOP;
      ARBop      = ARB_NOOP;
      rdEnnxt    = 1'b0;
      wrEnnxt    = 1'b0;
      case (state)
         S_RESET:  state_next = S_FETCH;
         S_FETCH: begin
            MARop      = MAR_PC;
            rdEnnxt    = 1'b1;
            state_next = S_FWAIT;
         end
         S_FWAIT: begin
            rdEnnxt    = 1'b1;
            state_next = S_LOADIR;
         end
         S_LOADIR: begin
            IRop       = IR_DATA;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            state_next = S_FETCH;
            // Opcodes 0x20-0x3F are ALU ops; bit 4 selects the literal operand.
            if (opcode[5]) begin
               ARAop      = ARA_RA;
               ARBop      = opcode[4] ? ARB_LIT : ARB_RB;
               state_next = S_ALUWB;
            end else begin
               case (opcode)
                  OP_HALT: state_next = S_HALT;
                  OP_PRINTC: begin
                     TXBUFop = printc_op(IR[20:0]);
                     PCop    = PC_INCR;
                  end
                  OP_PRINTS, OP_PRINTW: begin
                     MARop      = MAR_PC_INCR;
                     rdEnnxt    = 1'b1;
                     state_next = (opcode == OP_PRINTS) ? S_SWAIT : S_WWAIT;
                  end
                  OP_PRINTI: begin
                     TXBUFop = TX_INT_RA;
                     PCop    = PC_INCR;
                  end
                  OP_PRINTF: begin
                     TXBUFop = TX_FLOAT_RA;
                     PCop    = PC_INCR;
                  end
                  OP_LD, OP_LDR: begin
                     MARop      = (opcode == OP_LD) ? MAR_RA : MAR_JMP;
                     rdEnnxt    = 1'b1;
                     state_next = S_LDWAIT;
                  end
                  OP_ST: begin
                     MARop      = MAR_RA;
                     MDRop      = MDR_RC;
                     wrEnnxt    = 1'b1;
                     state_next = S_STWAIT;
                  end
                  OP_JMP: begin
                     RCop = RC_PC_INCR;
                     PCop = PC_RA;
                  end
                  OP_BEQ, OP_BNE: begin
                     RCop = RC_PC_INCR;
                     PCop = (RaZero == (opcode == OP_BEQ)) ? PC_JMP : PC_INCR;
                  end
                  default: begin
                     TXBUFop = TX_ERR;
                     PCop    = PC_INCR;
                  end
               endcase
            end
         end
         S_ALUWB: begin
            RCop       = RC_ARC;
            PCop       = PC_INCR;
            state_next = S_FETCH;
         end
         S_LDWAIT: begin
            rdEnnxt    = 1'b1;
            state_next = S_LDWB;
         end
         S_LDWB: begin
            RCop       = RC_DATA;
            PCop       = PC_INCR;
            state_next = S_FETCH;
         end
         S_STWAIT: begin
            wrEnnxt    = 1'b1;
            state_next = S_STDONE;
         end
         S_STDONE: begin
            PCop       = PC_INCR;
            state_next = S_FETCH;
         end
         S_SWAIT: begin
            rdEnnxt    = 1'b1;
            state_next = S_STREMIT;
         end
         S_STREMIT: begin
            TXBUFop = stremit_op(charsZero);
            // A full word means the string continues in the next word.
            if (charsZero == 4'hF) begin
               MARop      = MAR_INCR;
               rdEnnxt    = 1'b1;
               state_next = S_SWAIT;
            end else begin
               PCop       = PC_MAR;
               state_next = S_FETCH;
            end
         end
         S_WWAIT: begin
            rdEnnxt    = 1'b1;
            state_next = S_WEMIT;
         end
         S_WEMIT: begin
            TXBUFop    = TX_INT;
            PCop       = PC_INCR2;
            state_next = S_FETCH;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_RESET;
      endcase
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized bench for cpu_controller: a per-instruction reference model
// expands each instruction into its expected per-cycle output vectors.
module tb_cpu_controller;
   import cpu_controller_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] IR;
   logic        RaZero;
   logic [3:0]  charsZero;
   logic [2:0]  mar;
   logic        irop;
   logic        mdr;
   logic [2:0]  pc;
   logic [3:0]  tx;
   logic [1:0]  rc;
   logic        ara;
   logic [1:0]  arb;
   logic        rd;
   logic        wr;
   state_t      fsm_state;
   logic [18:0] obs;

   logic [18:0] exp_q[$];
   logic [3:0]  cz_q[$];
   logic [3:0]  force_q[$];
   int          total = 0;
   int          bad = 0;

   cpu_controller dut (
      .clk(clk), .reset(reset), .IR(IR), .RaZero(RaZero), .charsZero(charsZero),
      .MARop(mar), .IRop(irop), .MDRop(mdr), .PCop(pc), .TXBUFop(tx),
      .RCop(rc), .ARAop(ara), .ARBop(arb), .rdEnnxt(rd), .wrEnnxt(wr),
      .fsm_state(fsm_state)
   );

   assign obs = {mar, irop, mdr, pc, tx, rc, ara, arb, rd, wr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got mar=%0d ir=%0d mdr=%0d pc=%0d tx=%0d rc=%0d ara=%0d arb=%0d rd=%0d wr=%0d, expected mar=%0d ir=%0d mdr=%0d pc=%0d tx=%0d rc=%0d ara=%0d arb=%0d rd=%0d wr=%0d",
                  tag, got[18:16], got[15], got[14], got[13:11], got[10:7], got[6:5], got[4], got[3:2], got[1], got[0],
                  exp[18:16], exp[15], exp[14], exp[13:11], exp[10:7], exp[6:5], exp[4], exp[3:2], exp[1], exp[0]);
      end
   endtask

   function automatic logic [18:0] o(input logic [2:0] m, input logic i, input logic d,
                                     input logic [2:0] p, input logic [3:0] t, input logic [1:0] r,
                                     input logic a, input logic [1:0] b, input logic rde, input logic wre);
      return {m, i, d, p, t, r, a, b, rde, wre};
   endfunction

   task automatic push(input logic [18:0] v, input logic [3:0] cz);
      exp_q.push_back(v);
      cz_q.push_back(cz);
   endtask

   function automatic int lead_nonzero(input logic [3:0] cz);
      int k = 0;
      while (k < 4 && cz[3 - k]) k++;
      return k;
   endfunction

   // Expected behaviour of one instruction, fetch included.
   task automatic model_instr(input logic [31:0] ir_v, input logic rz);
      int          op;
      int          n;
      int          k;
      logic [3:0]  cz;
      op = int'(ir_v[31:26]);
      push(o(1,0,0,0,0,0,0,0,1,0), 4'($urandom));
      push(o(0,0,0,0,0,0,0,0,1,0), 4'($urandom));
      push(o(0,1,0,0,0,0,0,0,0,0), 4'($urandom));
      if (op >= 32 && op < 48) begin
         push(o(0,0,0,0,0,0,1,1,0,0), 4'($urandom));
         push(o(0,0,0,1,0,3,0,0,0,0), 4'($urandom));
      end else if (op >= 48) begin
         push(o(0,0,0,0,0,0,1,2,0,0), 4'($urandom));
         push(o(0,0,0,1,0,3,0,0,0,0), 4'($urandom));
      end else if (op == 'h18 || op == 'h1F) begin
         push(o((op == 'h18) ? 3'd3 : 3'd4,0,0,0,0,0,0,0,1,0), 4'($urandom));
         push(o(0,0,0,0,0,0,0,0,1,0), 4'($urandom));
         push(o(0,0,0,1,0,2,0,0,0,0), 4'($urandom));
      end else if (op == 'h19) begin
         push(o(3,0,1,0,0,0,0,0,0,1), 4'($urandom));
         push(o(0,0,0,0,0,0,0,0,0,1), 4'($urandom));
         push(o(0,0,0,1,0,0,0,0,0,0), 4'($urandom));
      end else if (op == 'h1B) begin
         push(o(0,0,0,3,0,1,0,0,0,0), 4'($urandom));
      end else if (op == 'h1C || op == 'h1D) begin
         n = ((op == 'h1C) == (rz == 1'b1)) ? 2 : 1;
         push(o(0,0,0,3'(n),0,1,0,0,0,0), 4'($urandom));
      end else if (op == 1) begin
         n = 0;
         if (ir_v[20:14] != 0) begin
            n = 1;
            if (ir_v[13:7] != 0) begin
               n = 2;
               if (ir_v[6:0] != 0) n = 3;
            end
         end
         push(o(0,0,0,1,(n == 0) ? 4'd0 : 4'(4 + n),0,0,0,0,0), 4'($urandom));
      end else if (op == 2) begin
         push(o(2,0,0,0,0,0,0,0,1,0), 4'($urandom));
         for (int rep = 0; rep < 8; rep++) begin
            push(o(0,0,0,0,0,0,0,0,1,0), 4'($urandom));
            if (force_q.size() > 0) cz = force_q.pop_front();
            else if (rep < 3 && $urandom_range(0, 1) == 1) cz = 4'hF;
            else cz = 4'($urandom_range(0, 14));
            k = lead_nonzero(cz);
            if (k == 4) begin
               push(o(5,0,0,0,4,0,0,0,1,0), cz);
            end else begin
               push(o(0,0,0,4,4'(k),0,0,0,0,0), cz);
               break;
            end
         end
      end else if (op == 3 || op == 4) begin
         push(o(0,0,0,1,(op == 3) ? 4'd11 : 4'd12,0,0,0,0,0), 4'($urandom));
      end else if (op == 5) begin
         push(o(2,0,0,0,0,0,0,0,1,0), 4'($urandom));
         push(o(0,0,0,0,0,0,0,0,1,0), 4'($urandom));
         push(o(0,0,0,5,9,0,0,0,0,0), 4'($urandom));
      end else if (op == 0) begin
         for (int h = 0; h < 6; h++) push(o(0,0,0,0,0,0,0,0,0,0), 4'($urandom));
      end else begin
         push(o(0,0,0,1,8,0,0,0,0,0), 4'($urandom));
      end
   endtask

   // Entered and left at posedge+1; outputs checked on the falling edge.
   task automatic run_instr(input string tag, input logic [31:0] ir_v, input logic rz);
      logic [18:0] v;
      IR     = ir_v;
      RaZero = rz;
      model_instr(ir_v, rz);
      while (exp_q.size() > 0) begin
         v         = exp_q.pop_front();
         charsZero = cz_q.pop_front();
         @(negedge clk);
         check(tag, obs, v);
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ir_v;
      logic [5:0]  op;
      ir_v = $urandom;
      case ($urandom_range(0, 15))
         0, 1:    op = 6'($urandom_range(1, 63));
         2:       op = 6'h01;
         3:       op = 6'h02;
         4:       op = 6'h03;
         5:       op = 6'h04;
         6:       op = 6'h05;
         7:       op = 6'h18;
         8:       op = 6'h19;
         9:       op = 6'h1F;
         10:      op = 6'h1B;
         11:      op = 6'h1C;
         12:      op = 6'h1D;
         13:      op = 6'h20 + 6'($urandom_range(0, 15));
         default: op = 6'h30 + 6'($urandom_range(0, 15));
      endcase
      ir_v[31:26] = op;
      if (op == 6'h01) begin
         case ($urandom_range(0, 3))
            0: ir_v[20:14] = 7'd0;
            1: ir_v[13:7]  = 7'd0;
            2: ir_v[6:0]   = 7'd0;
            default: ;
         endcase
      end
      return ir_v;
   endfunction

   initial begin
      reset     = 1'b0;
      IR        = 32'd0;
      RaZero    = 1'b0;
      charsZero = 4'd0;
      @(posedge clk); @(posedge clk); #1;
      check("reset_hold", obs, 19'd0);
      reset = 1'b1;
      @(negedge clk);
      check("reset_release", obs, 19'd0);
      @(posedge clk); #1;

      run_instr("add", 32'h80221000, 1'b0);
      run_instr("beq_taken", {6'h1C, 26'h0123456}, 1'b1);
      run_instr("beq_not_taken", {6'h1C, 26'h0123456}, 1'b0);
      run_instr("bne_taken", {6'h1D, 26'h3ABCDEF}, 1'b0);
      force_q.push_back(4'b1111);
      force_q.push_back(4'b1100);
      run_instr("prints", {6'h02, 26'h0}, 1'b0);
      run_instr("st", {6'h19, 26'h1555555}, 1'b0);
      run_instr("alu_lit", {6'h3F, 26'h2AAAAAA}, 1'b0);
      run_instr("bad_opcode", {6'h17, 26'h2AAAAAA}, 1'b0);
      run_instr("printc_none", {6'h01, 5'd0, 7'd0, 7'h41, 7'h42}, 1'b0);
      run_instr("printc_three", {6'h01, 5'd0, 7'h41, 7'h42, 7'h43}, 1'b0);

      for (int i = 0; i < 250; i++)
         run_instr("random", rand_instr(), 1'($urandom_range(0, 1)));

      // Reset asserted while a load is waiting on memory.
      IR = {6'h18, 26'h0};
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         @(posedge clk); #1;
      end
      check("ld_wait", obs, o(0,0,0,0,0,0,0,0,1,0));
      reset = 1'b0;
      #1;
      check("reset_async", obs, 19'd0);
      @(posedge clk); #1;
      check("reset_held", obs, 19'd0);
      reset = 1'b1;
      @(negedge clk);
      check("reset_rerelease", obs, 19'd0);
      @(posedge clk); #1;
      run_instr("after_reset", 32'h80221000, 1'b0);

      run_instr("halt", 32'h0, 1'b0);
      IR = 32'h80221000;
      @(negedge clk);
      check("halt_stays", obs, 19'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
